// File: rtl/home_sim_pkg.sv
// ---------------------------------------------------------------------------
// home_sim_pkg
// Shared constants and helpers for the home-simulation draw datapath.
// It holds the screen extents, the room tile geometry, the tile colours and
// the room-select helpers. It declares no ports.
// ---------------------------------------------------------------------------
package home_sim_pkg;

  // Screen extents (last column / last row)
  localparam logic [7:0] MAX_X = 8'd159;
  localparam logic [6:0] MAX_Y = 7'd119;

  // Room tile geometry
  localparam logic [7:0] ROOM_X_ORIGIN = 8'd8;
  localparam logic [7:0] ROOM_PITCH    = 8'd30;
  localparam logic [6:0] ROOM_Y_ORIGIN = 7'd50;

  localparam int NUM_ROOMS = 5;
  localparam int TILE_DIM  = 4;

  // funct select value meaning "light" (0 means door)
  localparam logic FUNCT_LIGHT = 1'b1;

  // Tile colours {R,G,B}
  localparam logic [2:0] COL_LIGHT_ON    = 3'b110;
  localparam logic [2:0] COL_LIGHT_OFF   = 3'b001;
  localparam logic [2:0] COL_DOOR_OPEN   = 3'b010;
  localparam logic [2:0] COL_DOOR_CLOSED = 3'b100;
  localparam logic [2:0] COL_BLACK       = 3'b000;

  typedef logic [2:0] room_idx_t;

  // Index of the lowest set enable bit. The loop scans downward, so the
  // lowest index is written last and wins when several bits are set.
  function automatic room_idx_t lowest_room(input logic [NUM_ROOMS-1:0] en);
    room_idx_t idx;
    idx = 3'd0;
    for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
      if (en[i]) begin
        idx = room_idx_t'(i);
      end
    end
    return idx;
  endfunction

  // x of a room tile's top-left pixel, truncated to 8 bits
  function automatic logic [7:0] room_x_base(input room_idx_t r);
    return ROOM_X_ORIGIN + ({5'd0, r} * ROOM_PITCH);
  endfunction

endpackage

// File: rtl/room_tile_draw_datapath_if.sv
// ---------------------------------------------------------------------------
// room_tile_draw_datapath_if
// Bundle between the control FSM (master) and the draw datapath (slave).
//   Controller -> datapath: room_en, clear_init, funct, onoff
//   Datapath -> controller: plotcounter, clear_x, clear_y, max_x, max_y,
//                           count_done, clear_done
//   Datapath -> VGA:        vga_x, vga_y, vga_colour, vga_plot
// ---------------------------------------------------------------------------
interface room_tile_draw_datapath_if;
  import home_sim_pkg::*;

  logic [NUM_ROOMS-1:0] room_en;
  logic                 clear_init;
  logic                 funct;
  logic                 onoff;

  logic [3:0]           plotcounter;
  logic [7:0]           clear_x;
  logic [6:0]           clear_y;
  logic [7:0]           max_x;
  logic [6:0]           max_y;
  logic                 count_done;
  logic                 clear_done;

  logic [7:0]           vga_x;
  logic [6:0]           vga_y;
  logic [2:0]           vga_colour;
  logic                 vga_plot;

  modport master (
    output room_en, clear_init, funct, onoff,
    input  plotcounter, clear_x, clear_y, max_x, max_y, count_done,
           clear_done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  room_en, clear_init, funct, onoff,
    output plotcounter, clear_x, clear_y, max_x, max_y, count_done,
           clear_done, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/screen_clear_counter.sv
// ---------------------------------------------------------------------------
// screen_clear_counter
// Raster sweep of (clear_x, clear_y) over the whole screen while
// clear_init is held. The sweep parks on the last pixel until the request
// drops, then returns to the origin on the next cycle.
//   clock, reset  : clock and synchronous active-high reset
//   clear_init_i  : sweep request, held for the whole sweep
//   clear_x_o/y_o : current sweep pixel
//   clear_done_o  : request active and sweep at the last pixel
// ---------------------------------------------------------------------------
module screen_clear_counter
  import home_sim_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_init_i,
  output logic [7:0] clear_x_o,
  output logic [6:0] clear_y_o,
  output logic       clear_done_o
);

  logic [7:0] clear_x_q, clear_x_d;
  logic [6:0] clear_y_q, clear_y_d;
  logic       at_max_s;

  assign at_max_s = (clear_x_q == MAX_X) && (clear_y_q == MAX_Y);

  // Next sweep position
  always_comb begin
    clear_x_d = clear_x_q;
    clear_y_d = clear_y_q;
    if (!clear_init_i) begin
      clear_x_d = 8'd0;
      clear_y_d = 7'd0;
    end else if (at_max_s) begin
      clear_x_d = clear_x_q;
      clear_y_d = clear_y_q;
    end else if (clear_x_q == MAX_X) begin
      clear_x_d = 8'd0;
      clear_y_d = clear_y_q + 7'd1;
    end else begin
      clear_x_d = clear_x_q + 8'd1;
      clear_y_d = clear_y_q;
    end
  end

  // Sweep position register
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_x_q <= 8'd0;
      clear_y_q <= 7'd0;
    end else begin
      clear_x_q <= clear_x_d;
      clear_y_q <= clear_y_d;
    end
  end

  assign clear_x_o    = clear_x_q;
  assign clear_y_o    = clear_y_q;
  assign clear_done_o = clear_init_i & at_max_s & ~reset;

endmodule

// File: rtl/room_tile_draw_datapath.sv
// ---------------------------------------------------------------------------
// room_tile_draw_datapath
// Draw-side responder to the home-simulation controller. It keeps the
// per-room light and door status, plots each room's 4x4 status tile and
// sweeps the screen black on a clear request.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : controller requests in; counters, done flags and VGA
//                  pixel stream out
// ---------------------------------------------------------------------------
module room_tile_draw_datapath
  import home_sim_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  room_tile_draw_datapath_if.slave   bus
);

  logic [NUM_ROOMS-1:0] light_q, light_d;
  logic [NUM_ROOMS-1:0] door_q, door_d;
  logic [3:0]           plotcounter_q, plotcounter_d;
  logic                 en_prev_q, en_prev_d;

  logic                 room_active_s;
  logic                 draw_s;
  logic                 first_s;
  logic                 write_light_s;
  logic                 write_door_s;
  room_idx_t            room_s;
  logic                 light_now_s;
  logic                 door_now_s;
  logic [2:0]           tile_colour_s;
  logic [7:0]           clear_x_s;
  logic [6:0]           clear_y_s;
  logic                 clear_done_s;

  assign room_active_s = |bus.room_en;
  assign room_s        = lowest_room(bus.room_en);
  // Clear has priority: a room request under clear is not a draw and
  // does not count as an activation.
  assign draw_s        = room_active_s & ~bus.clear_init;
  assign first_s       = draw_s & ~en_prev_q;
  assign write_light_s = first_s & (bus.funct == FUNCT_LIGHT);
  assign write_door_s  = first_s & (bus.funct != FUNCT_LIGHT);

  screen_clear_counter u_clear (
    .clock        (clock),
    .reset        (reset),
    .clear_init_i (bus.clear_init),
    .clear_x_o    (clear_x_s),
    .clear_y_o    (clear_y_s),
    .clear_done_o (clear_done_s)
  );

  // Next state: status write on activation, tile pixel counter, edge detect
  always_comb begin
    light_d       = light_q;
    door_d        = door_q;
    plotcounter_d = plotcounter_q;
    en_prev_d     = draw_s;
    if (write_light_s) begin
      light_d[room_s] = bus.onoff;
    end else if (write_door_s) begin
      door_d[room_s] = bus.onoff;
    end else begin
      light_d = light_q;
    end
    if (bus.clear_init) begin
      plotcounter_d = 4'd0;
    end else if (room_active_s) begin
      plotcounter_d = plotcounter_q + 4'd1;
    end else begin
      plotcounter_d = 4'd0;
    end
  end

  // Status and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      light_q       <= '0;
      door_q        <= '0;
      plotcounter_q <= 4'd0;
      en_prev_q     <= 1'b0;
    end else begin
      light_q       <= light_d;
      door_q        <= door_d;
      plotcounter_q <= plotcounter_d;
      en_prev_q     <= en_prev_d;
    end
  end

  // Tile colour; the status write is bypassed so the first pixel of a
  // tile already reflects the value being written this cycle.
  always_comb begin
    light_now_s = write_light_s ? bus.onoff : light_q[room_s];
    door_now_s  = write_door_s  ? bus.onoff : door_q[room_s];
    if (!plotcounter_q[3]) begin
      tile_colour_s = light_now_s ? COL_LIGHT_ON : COL_LIGHT_OFF;
    end else begin
      tile_colour_s = door_now_s ? COL_DOOR_OPEN : COL_DOOR_CLOSED;
    end
  end

  // Pixel stream mux: clear sweep, room tile, or idle
  always_comb begin
    bus.vga_x      = 8'd0;
    bus.vga_y      = 7'd0;
    bus.vga_colour = COL_BLACK;
    if (bus.clear_init) begin
      bus.vga_x      = clear_x_s;
      bus.vga_y      = clear_y_s;
      bus.vga_colour = COL_BLACK;
    end else if (room_active_s) begin
      bus.vga_x      = room_x_base(room_s) + {6'd0, plotcounter_q[1:0]};
      bus.vga_y      = ROOM_Y_ORIGIN + {5'd0, plotcounter_q[3:2]};
      bus.vga_colour = tile_colour_s;
    end else begin
      bus.vga_x      = 8'd0;
      bus.vga_y      = 7'd0;
      bus.vga_colour = COL_BLACK;
    end
  end

  assign bus.vga_plot    = (room_active_s | bus.clear_init) & ~reset;
  assign bus.count_done  = room_active_s & (plotcounter_q == 4'd15) & ~reset;
  assign bus.clear_done  = clear_done_s;
  assign bus.plotcounter = plotcounter_q;
  assign bus.clear_x     = clear_x_s;
  assign bus.clear_y     = clear_y_s;
  assign bus.max_x       = MAX_X;
  assign bus.max_y       = MAX_Y;

endmodule

// File: tb/tb_room_tile_draw_datapath.sv
// Scoreboard bench: stimulus pushes one expected entry per driven cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_room_tile_draw_datapath;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  room_tile_draw_datapath_if bus();

  room_tile_draw_datapath dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] pc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       plot;
    logic       cdone;
    logic       kdone;
    logic [7:0] cx;
    logic [6:0] cy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  logic [4:0] light_m;
  logic [4:0] door_m;

  exp_t mon_e;
  logic mon_ok;

  // Monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clock) begin
    if (q.size() > 0) begin
      mon_e  = q.pop_front();
      checks = checks + 1;
      mon_ok = (bus.plotcounter === mon_e.pc) && (bus.vga_plot === mon_e.plot) &&
               (bus.count_done === mon_e.cdone) && (bus.clear_done === mon_e.kdone) &&
               (bus.clear_x === mon_e.cx) && (bus.clear_y === mon_e.cy) &&
               (bus.max_x === 8'd159) && (bus.max_y === 7'd119);
      if (mon_e.plot) begin
        mon_ok = mon_ok && (bus.vga_x === mon_e.x) && (bus.vga_y === mon_e.y) &&
                 (bus.vga_colour === mon_e.col);
      end
      if (mon_ok) begin
        passes = passes + 1;
      end else begin
        $display("FAIL %s @%0t: got pc=%0d x=%0d y=%0d col=%b plot=%b cnt_done=%b clr_done=%b cx=%0d cy=%0d maxx=%0d maxy=%0d; want pc=%0d x=%0d y=%0d col=%b plot=%b cnt_done=%b clr_done=%b cx=%0d cy=%0d maxx=159 maxy=119",
                 mon_e.tag, $time, bus.plotcounter, bus.vga_x, bus.vga_y, bus.vga_colour,
                 bus.vga_plot, bus.count_done, bus.clear_done, bus.clear_x, bus.clear_y,
                 bus.max_x, bus.max_y, mon_e.pc, mon_e.x, mon_e.y, mon_e.col, mon_e.plot,
                 mon_e.cdone, mon_e.kdone, mon_e.cx, mon_e.cy);
      end
    end else if (bus.vga_plot === 1'b1) begin
      checks = checks + 1;
      $display("FAIL unexpected_plot @%0t: got vga_plot=1 want 0", $time);
    end
  end

  task automatic drive(input logic [4:0] en, input logic ci, input logic f,
                       input logic o, input logic rst, input exp_t e);
    @(posedge clock);
    #1;
    bus.room_en    = en;
    bus.clear_init = ci;
    bus.funct      = f;
    bus.onoff      = o;
    reset          = rst;
    q.push_back(e);
  endtask

  // Idle cycles; the first one still shows the counters left by the last edge
  task automatic idle(input int n, input logic [3:0] pc0, input logic [7:0] cx0,
                      input logic [6:0] cy0);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = "idle"; e.x = 8'd0; e.y = 7'd0; e.col = 3'b000;
      e.plot = 1'b0; e.cdone = 1'b0; e.kdone = 1'b0;
      e.pc = (i == 0) ? pc0 : 4'd0;
      e.cx = (i == 0) ? cx0 : 8'd0;
      e.cy = (i == 0) ? cy0 : 7'd0;
      drive(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, e);
    end
  endtask

  // n cycles of a room tile starting from plotcounter 0
  task automatic tile(input int room, input logic [4:0] en, input logic f,
                      input logic o, input int n, input string tag);
    exp_t e;
    int   p;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        if (f) light_m[room] = o;
        else   door_m[room]  = o;
      end
      p       = k % 16;
      e.tag   = tag;
      e.pc    = 4'(p);
      e.x     = 8'(8 + 30 * room + p % 4);
      e.y     = 7'(50 + p / 4);
      e.col   = (p < 8) ? (light_m[room] ? 3'b110 : 3'b001)
                        : (door_m[room]  ? 3'b010 : 3'b100);
      e.plot  = 1'b1;
      e.cdone = (p == 15);
      e.kdone = 1'b0;
      e.cx    = 8'd0;
      e.cy    = 7'd0;
      drive(en, 1'b0, f, o, 1'b0, e);
    end
  endtask

  initial begin
    exp_t e;
    bus.room_en = 5'b00000; bus.clear_init = 1'b0; bus.funct = 1'b0; bus.onoff = 1'b0;
    light_m = 5'b00000; door_m = 5'b00000;
    @(posedge clock);

    // Reset held with a room request: nothing plotted, counters at 0
    e.tag = "reset_state"; e.pc = 4'd0; e.x = 8'd0; e.y = 7'd0; e.col = 3'b000;
    e.plot = 1'b0; e.cdone = 1'b0; e.kdone = 1'b0; e.cx = 8'd0; e.cy = 7'd0;
    drive(5'b00001, 1'b0, 1'b1, 1'b1, 1'b1, e);

    tile(0, 5'b00001, 1'b1, 1'b1, 16, "room0_light_on");
    idle(1, 4'd0, 8'd0, 7'd0);
    tile(4, 5'b10000, 1'b0, 1'b1, 16, "room4_door_open");
    idle(1, 4'd0, 8'd0, 7'd0);
    tile(1, 5'b01010, 1'b1, 1'b1, 17, "room1_lowest_wins_wrap");
    idle(1, 4'd1, 8'd0, 7'd0);
    tile(3, 5'b01000, 1'b0, 1'b0, 16, "room3_untouched");
    idle(1, 4'd0, 8'd0, 7'd0);

    // Full clear sweep plus a few cycles parked on the last pixel
    for (int k = 0; k < 19203; k++) begin
      e.tag   = "clear_sweep";
      e.pc    = 4'd0;
      e.cx    = (k < 19199) ? 8'(k % 160) : 8'd159;
      e.cy    = (k < 19199) ? 7'(k / 160) : 7'd119;
      e.x     = e.cx;
      e.y     = e.cy;
      e.col   = 3'b000;
      e.plot  = 1'b1;
      e.cdone = 1'b0;
      e.kdone = (k >= 19199);
      drive(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, e);
    end
    idle(1, 4'd0, 8'd159, 7'd119);

    // Door of room 4 survives the clear
    tile(4, 5'b10000, 1'b1, 1'b0, 16, "room4_after_clear");
    idle(1, 4'd0, 8'd0, 7'd0);

    // Clear and room request together: clear wins, no status write
    for (int k = 0; k < 5; k++) begin
      e.tag = "clear_beats_room"; e.pc = 4'd0; e.cx = 8'(k); e.cy = 7'd0;
      e.x = 8'(k); e.y = 7'd0; e.col = 3'b000; e.plot = 1'b1;
      e.cdone = 1'b0; e.kdone = 1'b0;
      drive(5'b00100, 1'b1, 1'b1, 1'b1, 1'b0, e);
    end
    idle(1, 4'd0, 8'd5, 7'd0);

    // Abandoned tile, then re-raise as a new activation
    tile(2, 5'b00100, 1'b0, 1'b1, 10, "room2_partial");
    idle(1, 4'd10, 8'd0, 7'd0);
    tile(2, 5'b00100, 1'b1, 1'b1, 16, "room2_reraise");
    idle(1, 4'd0, 8'd0, 7'd0);

    // Reset while plotcounter is 7
    tile(4, 5'b10000, 1'b1, 1'b1, 7, "room4_pre_reset");
    e.tag = "reset_mid_tile"; e.pc = 4'd7; e.x = 8'd0; e.y = 7'd0; e.col = 3'b000;
    e.plot = 1'b0; e.cdone = 1'b0; e.kdone = 1'b0; e.cx = 8'd0; e.cy = 7'd0;
    drive(5'b10000, 1'b0, 1'b1, 1'b1, 1'b1, e);
    light_m = 5'b00000; door_m = 5'b00000;
    idle(1, 4'd0, 8'd0, 7'd0);
    tile(4, 5'b10000, 1'b0, 1'b0, 16, "room4_after_reset");
    idle(2, 4'd0, 8'd0, 7'd0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
    @(posedge clock);
    if (q.size() != 0) begin
      checks = checks + 1;
      $display("FAIL drain: got %0d entries left want 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
